// File: rtl/ram_arbiter_pkg.sv
// Purpose  : shared opcodes, FSM state and index types for the RAM arbiter.
// Latency  : n/a (type and constant definitions only).
// Backpress: n/a.
package ram_arb_pkg;

    // Command opcodes, carried in the top two bits of every RAM command
    localparam logic [1:0] WRITE_ADD  = 2'b00;
    localparam logic [1:0] WRITE_DATA = 2'b01;
    localparam logic [1:0] READ_ADD   = 2'b10;
    localparam logic [1:0] READ_DATA  = 2'b11;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Requester index: 0 = SPI slave command path, 1 = host/debug port
    typedef logic req_idx_t;

endpackage : ram_arb_pkg

// File: rtl/ram_arbiter_if.sv
// Purpose  : bundles requester commands, RAM command/response and lock status.
// Latency  : n/a (wires only).
// Backpress: req_ready qualifies req_valid per requester; responses have no backpressure.
// Ports    : slave  = arbiter side (drives ready, RAM command, responses, status)
//            master = requesters/RAM side (drives commands, RAM read data)
interface ram_arbiter_if #(
    parameter int ADDR_SIZE = 8
);
    logic [1:0]           req_valid;
    logic [ADDR_SIZE+1:0] req_cmd0;
    logic [ADDR_SIZE+1:0] req_cmd1;
    logic [1:0]           req_ready;
    logic [ADDR_SIZE+1:0] ram_din;
    logic                 ram_rx_valid;
    logic [7:0]           ram_dout;
    logic                 ram_tx_valid;
    logic [1:0]           rsp_valid;
    logic [7:0]           rsp_data;
    logic                 lock_owner;
    logic                 locked;
    logic                 lock_timeout;

    modport slave (
        input  req_valid, req_cmd0, req_cmd1, ram_dout, ram_tx_valid,
        output req_ready, ram_din, ram_rx_valid, rsp_valid, rsp_data,
               lock_owner, locked, lock_timeout
    );

    modport master (
        output req_valid, req_cmd0, req_cmd1, ram_dout, ram_tx_valid,
        input  req_ready, ram_din, ram_rx_valid, rsp_valid, rsp_data,
               lock_owner, locked, lock_timeout
    );
endinterface : ram_arbiter_if

// File: rtl/ram_arbiter_rr_arbiter2.sv
// Purpose  : two-way round-robin pick; returns a one-hot grant from valid + pointer.
// Latency  : combinational.
// Backpress: none; a zero grant simply means nobody is requesting.
// Ports    : valid_i request vector, ptr_i favoured index on contention, grant_o one-hot.
module rr_arbiter2
    import ram_arb_pkg::*;
(
    input  logic [1:0] valid_i,
    input  req_idx_t   ptr_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = valid_i;
        if (valid_i == 2'b11) begin
            grant_o = ptr_i ? 2'b10 : 2'b01;
        end
    end

endmodule : rr_arbiter2

// File: rtl/ram_arbiter.sv
// Purpose  : round-robin arbiter for the shared 256x8 RAM with ADD..DATA ownership lock.
// Latency  : accept -> ram_rx_valid next cycle; READ_DATA accept -> rsp_valid 2 cycles later.
// Backpress: req_ready per requester (only the owner while locked); one command per cycle.
// Ports    : clk, rst_n (sync, active-low), bus = ram_arbiter_if.slave
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int LOCK_TIMEOUT = 16,
    parameter int ADDR_SIZE    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    ram_arbiter_if.slave  bus
);

    localparam int CW = ADDR_SIZE + 2;
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(LOCK_TIMEOUT - 1);

    arb_state_e     state_q, state_d;
    req_idx_t       ptr_q, ptr_d;
    req_idx_t       owner_q, owner_d;
    logic [TW-1:0]  timer_q, timer_d;

    logic [CW-1:0]  din_q;
    logic           rx_q;
    logic           rd_q;       // READ_DATA sits in the RAM command register
    req_idx_t       tag_q;      // its issuer
    logic           pend_q;     // RAM has sampled that READ_DATA; response due
    req_idx_t       pend_tag_q;

    logic [1:0]     grant;
    logic [1:0]     ready;
    logic [1:0]     xfer;
    logic           accept;
    req_idx_t       sel;
    logic [CW-1:0]  sel_cmd;
    logic [1:0]     sel_op;
    logic           sel_is_add;
    logic           owner_xfer;
    logic           expire;

    rr_arbiter2 u_rr (
        .valid_i (bus.req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant)
    );

    always_comb begin
        ready = 2'b00;
        if (rst_n) begin
            if (state_q == IDLE) begin
                ready = grant;
            end else begin
                ready[owner_q] = 1'b1;
            end
        end
    end

    // ready is never two-hot, so xfer[1] alone identifies the accepted requester
    assign xfer       = bus.req_valid & ready;
    assign accept     = |xfer;
    assign sel        = xfer[1];
    assign sel_cmd    = sel ? bus.req_cmd1 : bus.req_cmd0;
    assign sel_op     = sel_cmd[CW-1 -: 2];
    assign sel_is_add = (sel_op == WRITE_ADD) || (sel_op == READ_ADD);

    // An owner transfer in the expiry cycle takes precedence over the timeout
    assign owner_xfer = xfer[owner_q];
    assign expire     = rst_n && (state_q == LOCKED) && !owner_xfer && (timer_q == TIMER_LAST);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        timer_d = timer_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.req_valid == 2'b11) begin
                        ptr_d = ~ptr_q;
                    end
                    if (sel_is_add) begin
                        state_d = LOCKED;
                        owner_d = sel;
                        timer_d = '0;
                    end
                end
            end
            LOCKED: begin
                if (owner_xfer) begin
                    if (sel_is_add) begin
                        timer_d = '0;
                    end else begin
                        state_d = IDLE;
                        ptr_d   = ~owner_q;
                    end
                end else if (expire) begin
                    state_d = IDLE;
                    ptr_d   = ~owner_q;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= 1'b0;
            owner_q    <= 1'b0;
            timer_q    <= '0;
            din_q      <= '0;
            rx_q       <= 1'b0;
            rd_q       <= 1'b0;
            tag_q      <= 1'b0;
            pend_q     <= 1'b0;
            pend_tag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            timer_q <= timer_d;
            rx_q    <= accept;
            rd_q    <= accept && (sel_op == READ_DATA);
            if (accept) begin
                din_q <= sel_cmd;
                tag_q <= sel;
            end
            // Tag follows the command into the RAM; a new read sampled by the
            // RAM replaces a retiring one on the same edge
            if (rd_q) begin
                pend_q     <= 1'b1;
                pend_tag_q <= tag_q;
            end else if (bus.ram_tx_valid) begin
                pend_q <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.rsp_valid = 2'b00;
        if (pend_q && bus.ram_tx_valid) begin
            bus.rsp_valid[pend_tag_q] = 1'b1;
        end
    end

    assign bus.req_ready    = ready;
    assign bus.ram_din      = din_q;
    assign bus.ram_rx_valid = rx_q;
    assign bus.rsp_data     = bus.ram_dout;
    assign bus.lock_owner   = owner_q;
    assign bus.locked       = (state_q == LOCKED);
    assign bus.lock_timeout = expire;

endmodule : ram_arbiter

// File: tb/tb_ram_arbiter.sv
// Purpose  : directed vector bench for ram_arbiter with a behavioural 256x8 RAM.
// Latency  : inputs driven on the falling edge, outputs sampled 1 ns later.
// Backpress: n/a.
module tb_ram_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_arbiter_if #(.ADDR_SIZE(8)) bus ();

    ram_arbiter #(.LOCK_TIMEOUT(16), .ADDR_SIZE(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural RAM: ADD commands latch an address, WRITE_DATA writes,
    // READ_DATA returns data with tx_valid on the cycle after sampling.
    logic [7:0] mem [256];
    logic [7:0] wr_addr = 8'h00;
    logic [7:0] rd_addr = 8'h00;
    logic       ram_tx  = 1'b0;
    logic       inj_tx  = 1'b0;     // stray response pulse, unrelated to any command

    assign bus.ram_tx_valid = ram_tx | inj_tx;

    always @(posedge clk) begin
        ram_tx <= 1'b0;
        if (bus.ram_rx_valid) begin
            case (bus.ram_din[9:8])
                2'b00: wr_addr <= bus.ram_din[7:0];
                2'b01: mem[wr_addr] <= bus.ram_din[7:0];
                2'b10: rd_addr <= bus.ram_din[7:0];
                default: begin
                    bus.ram_dout <= mem[rd_addr];
                    ram_tx       <= 1'b1;
                end
            endcase
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic [1:0] v, input logic [9:0] c0,
                        input logic [9:0] c1, input logic inj);
        @(negedge clk);
        rst_n         = rst;
        bus.req_valid = v;
        bus.req_cmd0  = c0;
        bus.req_cmd1  = c1;
        inj_tx        = inj;
        #1;
    endtask

    typedef struct {
        logic       rst;
        logic [1:0] v;
        logic [9:0] c0;
        logic [9:0] c1;
        logic [1:0] rdy;
        logic       rx;
        logic [9:0] din;
        logic       lck;
        logic       own;
        logic [1:0] rsp;
        logic [7:0] dat;
    } vec_t;

    vec_t tbl [15];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        bus.ram_dout  = 8'h00;
        bus.req_valid = 2'b00;
        bus.req_cmd0  = '0;
        bus.req_cmd1  = '0;

        //          rst  v      c0      c1      rdy    rx  din     lck  own  rsp    dat
        // write 0x10 <- A5 from req0, read it back from req1
        tbl[0]  = '{1'b0, 2'b11, 10'h010, 10'h210, 2'b00, 1'b0, 10'h000, 1'b0, 1'b0, 2'b00, 8'h00};
        tbl[1]  = '{1'b1, 2'b01, 10'h010, 10'h000, 2'b01, 1'b0, 10'h000, 1'b0, 1'b0, 2'b00, 8'h00};
        tbl[2]  = '{1'b1, 2'b01, 10'h1A5, 10'h000, 2'b01, 1'b1, 10'h010, 1'b1, 1'b0, 2'b00, 8'h00};
        tbl[3]  = '{1'b1, 2'b10, 10'h000, 10'h210, 2'b10, 1'b1, 10'h1A5, 1'b0, 1'b0, 2'b00, 8'h00};
        tbl[4]  = '{1'b1, 2'b10, 10'h000, 10'h300, 2'b10, 1'b1, 10'h210, 1'b1, 1'b1, 2'b00, 8'h00};
        tbl[5]  = '{1'b1, 2'b00, 10'h000, 10'h000, 2'b00, 1'b1, 10'h300, 1'b0, 1'b1, 2'b00, 8'h00};
        tbl[6]  = '{1'b1, 2'b00, 10'h000, 10'h000, 2'b00, 1'b0, 10'h000, 1'b0, 1'b1, 2'b10, 8'hA5};
        tbl[7]  = '{1'b1, 2'b00, 10'h000, 10'h000, 2'b00, 1'b0, 10'h000, 1'b0, 1'b1, 2'b00, 8'h00};
        // reset, then both request READ_ADD: req0 first, req1 waits for req0's READ_DATA
        tbl[8]  = '{1'b0, 2'b11, 10'h220, 10'h230, 2'b00, 1'b0, 10'h000, 1'b0, 1'b1, 2'b00, 8'h00};
        tbl[9]  = '{1'b1, 2'b11, 10'h220, 10'h230, 2'b01, 1'b0, 10'h000, 1'b0, 1'b0, 2'b00, 8'h00};
        tbl[10] = '{1'b1, 2'b11, 10'h300, 10'h230, 2'b01, 1'b1, 10'h220, 1'b1, 1'b0, 2'b00, 8'h00};
        tbl[11] = '{1'b1, 2'b10, 10'h000, 10'h230, 2'b10, 1'b1, 10'h300, 1'b0, 1'b0, 2'b00, 8'h00};
        tbl[12] = '{1'b1, 2'b10, 10'h000, 10'h300, 2'b10, 1'b1, 10'h230, 1'b1, 1'b1, 2'b01, 8'h00};
        tbl[13] = '{1'b1, 2'b00, 10'h000, 10'h000, 2'b00, 1'b1, 10'h300, 1'b0, 1'b1, 2'b00, 8'h00};
        tbl[14] = '{1'b1, 2'b00, 10'h000, 10'h000, 2'b00, 1'b0, 10'h000, 1'b0, 1'b1, 2'b10, 8'h00};

        // two reset edges before the table so registered outputs are defined
        repeat (2) @(posedge clk);

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].rst, tbl[i].v, tbl[i].c0, tbl[i].c1, 1'b0);
            chk($sformatf("r%0d.req_ready", i), 32'(bus.req_ready), 32'(tbl[i].rdy));
            chk($sformatf("r%0d.ram_rx_valid", i), 32'(bus.ram_rx_valid), 32'(tbl[i].rx));
            if (tbl[i].rx)
                chk($sformatf("r%0d.ram_din", i), 32'(bus.ram_din), 32'(tbl[i].din));
            chk($sformatf("r%0d.locked", i), 32'(bus.locked), 32'(tbl[i].lck));
            chk($sformatf("r%0d.lock_owner", i), 32'(bus.lock_owner), 32'(tbl[i].own));
            chk($sformatf("r%0d.lock_timeout", i), 32'(bus.lock_timeout), 32'd0);
            chk($sformatf("r%0d.rsp_valid", i), 32'(bus.rsp_valid), 32'(tbl[i].rsp));
            if (tbl[i].rsp != 2'b00)
                chk($sformatf("r%0d.rsp_data", i), 32'(bus.rsp_data), 32'(tbl[i].dat));
        end

        // Lock timeout: req0 locks then goes silent while req1 waits
        step(1'b1, 2'b01, 10'h040, 10'h000, 1'b0);
        chk("to.lock_rdy", 32'(bus.req_ready), 32'b01);
        for (int k = 1; k <= 16; k++) begin
            step(1'b1, 2'b10, 10'h000, 10'h050, 1'b0);
            chk($sformatf("to.c%0d.req_ready", k), 32'(bus.req_ready), 32'b01);
            chk($sformatf("to.c%0d.locked", k), 32'(bus.locked), 32'd1);
            chk($sformatf("to.c%0d.lock_timeout", k), 32'(bus.lock_timeout), (k == 16) ? 32'd1 : 32'd0);
        end
        step(1'b1, 2'b10, 10'h000, 10'h050, 1'b0);
        chk("to.after.locked", 32'(bus.locked), 32'd0);
        chk("to.after.lock_timeout", 32'(bus.lock_timeout), 32'd0);
        chk("to.after.req_ready", 32'(bus.req_ready), 32'b10);
        step(1'b1, 2'b10, 10'h000, 10'h155, 1'b0);
        chk("to.req1.locked", 32'(bus.locked), 32'd1);
        chk("to.req1.lock_owner", 32'(bus.lock_owner), 32'd1);
        chk("to.req1.ram_din", 32'(bus.ram_din), 32'h050);

        // Owner WRITE_DATA lands on the expiry cycle: transfer wins
        step(1'b1, 2'b01, 10'h060, 10'h000, 1'b0);
        chk("sim.lock_rdy", 32'(bus.req_ready), 32'b01);
        for (int k = 1; k <= 15; k++) begin
            step(1'b1, 2'b00, 10'h000, 10'h000, 1'b0);
            chk($sformatf("sim.c%0d.lock_timeout", k), 32'(bus.lock_timeout), 32'd0);
            chk($sformatf("sim.c%0d.locked", k), 32'(bus.locked), 32'd1);
        end
        step(1'b1, 2'b01, 10'h177, 10'h000, 1'b0);
        chk("sim.c16.lock_timeout", 32'(bus.lock_timeout), 32'd0);
        chk("sim.c16.req_ready", 32'(bus.req_ready), 32'b01);
        step(1'b1, 2'b00, 10'h000, 10'h000, 1'b0);
        chk("sim.after.locked", 32'(bus.locked), 32'd0);
        chk("sim.after.ram_rx_valid", 32'(bus.ram_rx_valid), 32'd1);
        chk("sim.after.ram_din", 32'(bus.ram_din), 32'h177);
        chk("sim.after.lock_timeout", 32'(bus.lock_timeout), 32'd0);

        // Reset while locked with a read outstanding, then stray tx_valid pulses
        step(1'b1, 2'b10, 10'h000, 10'h210, 1'b0);
        chk("rst.ra.req_ready", 32'(bus.req_ready), 32'b10);
        step(1'b1, 2'b10, 10'h000, 10'h300, 1'b0);
        chk("rst.rd.locked", 32'(bus.locked), 32'd1);
        chk("rst.rd.req_ready", 32'(bus.req_ready), 32'b10);
        step(1'b1, 2'b01, 10'h070, 10'h000, 1'b0);
        chk("rst.wa.req_ready", 32'(bus.req_ready), 32'b01);
        step(1'b0, 2'b01, 10'h1EE, 10'h000, 1'b0);
        chk("rst.low.locked", 32'(bus.locked), 32'd1);
        chk("rst.low.req_ready", 32'(bus.req_ready), 32'b00);
        chk("rst.low.rsp_valid", 32'(bus.rsp_valid), 32'b10);
        chk("rst.low.rsp_data", 32'(bus.rsp_data), 32'hA5);
        chk("rst.low.lock_timeout", 32'(bus.lock_timeout), 32'd0);
        step(1'b0, 2'b00, 10'h000, 10'h000, 1'b1);
        chk("rst.out.ram_rx_valid", 32'(bus.ram_rx_valid), 32'd0);
        chk("rst.out.ram_din", 32'(bus.ram_din), 32'h000);
        chk("rst.out.locked", 32'(bus.locked), 32'd0);
        chk("rst.out.lock_owner", 32'(bus.lock_owner), 32'd0);
        chk("rst.out.lock_timeout", 32'(bus.lock_timeout), 32'd0);
        chk("rst.out.rsp_valid", 32'(bus.rsp_valid), 32'b00);
        step(1'b1, 2'b00, 10'h000, 10'h000, 1'b1);
        chk("rst.stray.rsp_valid", 32'(bus.rsp_valid), 32'b00);
        chk("rst.stray.locked", 32'(bus.locked), 32'd0);

        // READ_DATA without ADD from req1: forwarded, stays IDLE, routed to req1
        step(1'b1, 2'b10, 10'h000, 10'h300, 1'b0);
        chk("nad.req_ready", 32'(bus.req_ready), 32'b10);
        step(1'b1, 2'b00, 10'h000, 10'h000, 1'b0);
        chk("nad.locked", 32'(bus.locked), 32'd0);
        chk("nad.ram_rx_valid", 32'(bus.ram_rx_valid), 32'd1);
        chk("nad.ram_din", 32'(bus.ram_din), 32'h300);
        step(1'b1, 2'b00, 10'h000, 10'h000, 1'b0);
        chk("nad.rsp_valid", 32'(bus.rsp_valid), 32'b10);
        chk("nad.rsp_data", 32'(bus.rsp_data), 32'hA5);
        chk("nad.rsp.locked", 32'(bus.locked), 32'd0);
        step(1'b1, 2'b00, 10'h000, 10'h000, 1'b0);
        chk("nad.rsp_done", 32'(bus.rsp_valid), 32'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_ram_arbiter
